// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// state encodings, default parameter values and a width helper.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PART  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    localparam int         N_DEF       = 4;
    localparam logic [3:0] PATTERN_DEF = 4'b1011;
    localparam int         CW_DEF      = 8;

    // Bits needed to hold a fill count from 0 up to and including n.
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// N-bit history shift register with a saturating fill counter.
// Exposes the shifted/incremented candidates so the top can decide a match before the edge.
module seq_det_shreg
    import seq_det_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int FW = fill_width(N)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          fill_clr,
    input  logic          din,
    output logic [N-1:0]  hist_q,
    output logic [FW-1:0] fill_q,
    output logic [N-1:0]  hist_sh,
    output logic [FW-1:0] fill_inc
);

    localparam logic [FW-1:0] FILL_MAX = FW'(N);

    logic [N-1:0]  hist_d;
    logic [FW-1:0] fill_d;

    always_comb begin
        hist_sh  = {hist_q[N-2:0], din};
        fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);

        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = hist_sh;
            fill_d = fill_clr ? '0 : fill_inc;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Serial-bit sequence detector against a runtime-loadable N-bit pattern, overlapping or not.
// Define SEQ_DET_MATCH_COUNT_EN to add the saturating match_cnt output.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int           N       = N_DEF,
    parameter logic [N-1:0] PATTERN = N'(PATTERN_DEF),
    parameter int           CW      = CW_DEF
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          en,
    input  logic          din,
    input  logic          ovl,
    input  logic          cfg_load,
    input  logic [N-1:0]  cfg_pat,
    output logic          dout,
    output logic [1:0]    state
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    output logic [CW-1:0] match_cnt
`endif
);

    localparam int            FW       = fill_width(N);
    localparam logic [FW-1:0] FILL_MAX = FW'(N);

    logic [N-1:0]  hist_q;
    logic [N-1:0]  hist_sh;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_inc;
    logic [N-1:0]  pat_q;
    logic [N-1:0]  pat_d;
    logic          dout_q;
    logic          dout_d;
    logic          match;
    logic          fill_clr;
    state_e        state_s;

    seq_det_shreg #(.N(N)) u_shreg (
        .ck       (ck),
        .rst      (rst),
        .en       (en),
        .clr      (cfg_load),
        .fill_clr (fill_clr),
        .din      (din),
        .hist_q   (hist_q),
        .fill_q   (fill_q),
        .hist_sh  (hist_sh),
        .fill_inc (fill_inc)
    );

    // A match is judged on the post-shift window; a load always wins and drops the sample.
    always_comb begin
        match    = en && !cfg_load && (fill_inc == FILL_MAX) && (hist_sh == pat_q);
        fill_clr = match && !ovl;
        pat_d    = cfg_load ? cfg_pat : pat_q;
        dout_d   = match;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            pat_q  <= PATTERN;
            dout_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            dout_q <= dout_d;
        end
    end

    always_comb begin
        state_s = ST_PART;
        if (fill_q == '0) begin
            state_s = ST_IDLE;
        end else if (fill_q == FILL_MAX) begin
            state_s = ST_ARMED;
        end
    end

    assign dout  = dout_q;
    assign state = state_s;

`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counts on the same edge that raises dout, so the two move together.
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    // Counter width only matters when the counter is built; keep an elaboration marker for bad sizes.
    if (CW < 1 || N < 2 || N > 16) begin : g_illegal_params
    end
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param (N=4, PATTERN=1011): table-driven vectors through a
// scoreboard queue, plus hand-written async-reset and match-counter sequences.
module tb_seq_det_param;
    import seq_det_pkg::*;

    logic       ck = 1'b0;
    logic       rst;
    logic       en;
    logic       din;
    logic       ovl;
    logic       cfg_load;
    logic [3:0] cfg_pat;
    logic       dout;
    logic [1:0] state;

`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [7:0] match_cnt;
    logic       en6;
    logic       din6;
    logic       ovl6;
    logic       ld6;
    logic [3:0] pat6;
    logic       dout6;
    logic [1:0] state6;
    logic [1:0] cnt6;
`endif

    seq_det_param #(.N(4), .PATTERN(4'b1011), .CW(8)) dut (
        .ck        (ck),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .ovl       (ovl),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat),
        .dout      (dout),
        .state     (state)
`ifdef SEQ_DET_MATCH_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

`ifdef SEQ_DET_MATCH_COUNT_EN
    seq_det_param #(.N(4), .PATTERN(4'b1111), .CW(2)) dut6 (
        .ck        (ck),
        .rst       (rst),
        .en        (en6),
        .din       (din6),
        .ovl       (ovl6),
        .cfg_load  (ld6),
        .cfg_pat   (pat6),
        .dout      (dout6),
        .state     (state6),
        .match_cnt (cnt6)
    );
`endif

    always #5 ck = ~ck;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       dout;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        logic [3:0] tst;
        logic       en;
        logic       din;
        logic       ovl;
        logic       ld;
        logic [3:0] pat;
        logic       xd;
        logic [1:0] xs;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    localparam logic [3:0] P1011 = 4'b1011;
    localparam logic [3:0] P0110 = 4'b0110;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic apply(input string name, input logic e, input logic d, input logic o,
                         input logic l, input logic [3:0] p, input logic xd, input logic [1:0] xs);
        exp_t x;
        exp_t got_exp;
        en       = e;
        din      = d;
        ovl      = o;
        cfg_load = l;
        cfg_pat  = p;
        x.dout   = xd;
        x.st     = xs;
        sb_q.push_back(x);
        @(posedge ck);
        #1;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            got_exp = sb_q.pop_front();
            check(name, 8'({dout, state}), 8'(got_exp));
        end
    endtask

    function automatic void add(input int tst, input logic e, input logic d, input logic o,
                                input logic l, input logic [3:0] p, input logic xd,
                                input logic [1:0] xs);
        vec_t v;
        v.tst = 4'(tst);
        v.en  = e;
        v.din = d;
        v.ovl = o;
        v.ld  = l;
        v.pat = p;
        v.xd  = xd;
        v.xs  = xs;
        vecs.push_back(v);
    endfunction

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        din      = 1'b0;
        ovl      = 1'b1;
        cfg_load = 1'b0;
        cfg_pat  = 4'h0;
`ifdef SEQ_DET_MATCH_COUNT_EN
        en6  = 1'b0;
        din6 = 1'b0;
        ovl6 = 1'b1;
        ld6  = 1'b0;
        pat6 = 4'hF;
`endif

        // Test 1: overlapping, 1011011 -> pulses after bits 4 and 7.
        add(1, 1, 1, 1, 0, 0, 0, ST_PART);
        add(1, 1, 0, 1, 0, 0, 0, ST_PART);
        add(1, 1, 1, 1, 0, 0, 0, ST_PART);
        add(1, 1, 1, 1, 0, 0, 1, ST_ARMED);
        add(1, 1, 0, 1, 0, 0, 0, ST_ARMED);
        add(1, 1, 1, 1, 0, 0, 0, ST_ARMED);
        add(1, 1, 1, 1, 0, 0, 1, ST_ARMED);
        // Test 2: non-overlapping, same stream -> one pulse, fill restarts.
        add(2, 0, 0, 0, 1, P1011, 0, ST_IDLE);
        add(2, 1, 1, 0, 0, 0, 0, ST_PART);
        add(2, 1, 0, 0, 0, 0, 0, ST_PART);
        add(2, 1, 1, 0, 0, 0, 0, ST_PART);
        add(2, 1, 1, 0, 0, 0, 1, ST_IDLE);
        add(2, 1, 0, 0, 0, 0, 0, ST_PART);
        add(2, 1, 1, 0, 0, 0, 0, ST_PART);
        add(2, 1, 1, 0, 0, 0, 0, ST_PART);
        // Test 4: enable gap holds history.
        add(4, 0, 0, 1, 1, P1011, 0, ST_IDLE);
        add(4, 1, 1, 1, 0, 0, 0, ST_PART);
        add(4, 1, 0, 1, 0, 0, 0, ST_PART);
        add(4, 0, 1, 1, 0, 0, 0, ST_PART);
        add(4, 0, 1, 1, 0, 0, 0, ST_PART);
        add(4, 1, 1, 1, 0, 0, 0, ST_PART);
        add(4, 1, 1, 1, 0, 0, 1, ST_ARMED);
        // Test 5: load a new pattern mid-fill; the sample on the load edge is dropped.
        add(5, 0, 0, 1, 1, P1011, 0, ST_IDLE);
        add(5, 1, 1, 1, 0, 0, 0, ST_PART);
        add(5, 1, 1, 1, 0, 0, 0, ST_PART);
        add(5, 1, 1, 1, 0, 0, 0, ST_PART);
        add(5, 1, 1, 1, 1, P0110, 0, ST_IDLE);
        add(5, 1, 0, 1, 0, 0, 0, ST_PART);
        add(5, 1, 1, 1, 0, 0, 0, ST_PART);
        add(5, 1, 1, 1, 0, 0, 0, ST_PART);
        add(5, 1, 0, 1, 0, 0, 1, ST_ARMED);
        add(5, 1, 1, 1, 0, 0, 0, ST_ARMED);
        // Test 7: ovl only matters on the matching edge.
        add(7, 0, 0, 0, 1, P1011, 0, ST_IDLE);
        add(7, 1, 1, 0, 0, 0, 0, ST_PART);
        add(7, 1, 0, 0, 0, 0, 0, ST_PART);
        add(7, 1, 1, 0, 0, 0, 0, ST_PART);
        add(7, 1, 1, 1, 0, 0, 1, ST_ARMED);
        add(7, 1, 0, 0, 0, 0, 0, ST_ARMED);
        add(7, 1, 1, 0, 0, 0, 0, ST_ARMED);
        add(7, 1, 1, 0, 0, 0, 1, ST_IDLE);
        add(7, 1, 1, 0, 0, 0, 0, ST_PART);

        // Reset state.
        #12;
        check("reset_dout", 8'(dout), 8'd0);
        check("reset_state", 8'(state), 8'(ST_IDLE));
        @(negedge ck);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("t%0d_v%0d", vecs[i].tst, i), vecs[i].en, vecs[i].din, vecs[i].ovl,
                  vecs[i].ld, vecs[i].pat, vecs[i].xd, vecs[i].xs);
        end

        // Test 3: async reset mid-stream; reset also restores the default pattern.
        apply("t3_load0", 0, 0, 1, 1, 4'h0, 0, ST_IDLE);
        apply("t3_b1", 1, 1, 1, 0, 0, 0, ST_PART);
        apply("t3_b2", 1, 0, 1, 0, 0, 0, ST_PART);
        apply("t3_b3", 1, 1, 1, 0, 0, 0, ST_PART);
        #2;
        rst = 1'b1;
        #1;
        check("t3_async_dout", 8'(dout), 8'd0);
        check("t3_async_state", 8'(state), 8'(ST_IDLE));
        apply("t3_hold", 1, 1, 1, 0, 0, 0, ST_IDLE);
        #3;
        rst = 1'b0;
        apply("t3_p1", 1, 1, 1, 0, 0, 0, ST_PART);
        apply("t3_p2", 1, 0, 1, 0, 0, 0, ST_PART);
        apply("t3_p3", 1, 1, 1, 0, 0, 0, ST_PART);
        apply("t3_p4", 1, 1, 1, 0, 0, 1, ST_ARMED);
        apply("t3_idle", 0, 0, 1, 0, 0, 0, ST_ARMED);

`ifdef SEQ_DET_MATCH_COUNT_EN
        // Test 6: 2-bit saturating counter on an all-ones pattern.
        for (int k = 1; k <= 8; k++) begin
            en6  = 1'b1;
            din6 = 1'b1;
            @(posedge ck);
            #1;
            check($sformatf("t6_dout_%0d", k), 8'(dout6), (k >= 4) ? 8'd1 : 8'd0);
            check($sformatf("t6_cnt_%0d", k), 8'(cnt6),
                  (k < 4) ? 8'd0 : ((k - 3 > 3) ? 8'd3 : 8'(k - 3)));
        end
        en6 = 1'b0;
        ld6 = 1'b1;
        @(posedge ck);
        #1;
        ld6 = 1'b0;
        check("t6_cnt_clr", 8'(cnt6), 8'd0);
        check("t6_state_clr", 8'(state6), 8'(ST_IDLE));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
